bg_config_ctrl: RTL

BG_CONFIG_CTRL -- requirements
Module: bg_config_ctrl

---
 rtl/bg_config_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bg_config_ctrl.sv
// Background configuration controller: applies fill/edge-marker updates from two
// requesters at frame boundaries, one per frame, with round-robin arbitration.
module bg_config_ctrl #(
    parameter int          STARTUP_FRAMES = 2,
    parameter logic [11:0] DEFAULT_FILL   = 12'h888
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vblnk_in,
    input  logic        req0,
    input  logic        req1,
    input  logic [11:0] fill0,
    input  logic [11:0] fill1,
    input  logic        bord0,
    input  logic        bord1,
    output logic        ack0,
    output logic        ack1,
    output logic [11:0] fill_rgb_out,
    output logic        border_en_out,
    output logic        blank_out,
    output logic [15:0] frame_cnt,
    output logic        pending
);

    localparam int SW = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VBL = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t          state_reg;
    logic            vblnk_reg;
    logic            vbl_rise;
    logic            ptr_reg;
    logic            last_grant_reg;
    logic [1:0]      ack_reg;
    logic            pending_reg;
    logic [11:0]     fill_reg;
    logic            bord_reg;
    logic            blank_reg;
    logic [SW-1:0]   startup_cnt_reg;
    logic [15:0]     frame_cnt_reg;

    logic [1:0]      req_vec;
    logic [1:0]      grant_next;
    logic [1:0]      pend_next;

    assign req_vec  = {req1, req0};
    assign vbl_rise = vblnk_in & ~vblnk_reg;

    // One-hot grant issued on the clock edge that ends the vbl_rise cycle.
    always_comb begin
        grant_next = 2'b00;
        if (state_reg == WAIT_VBL && vbl_rise) begin
            case (req_vec)
                2'b01:   grant_next = 2'b01;
                2'b10:   grant_next = 2'b10;
                2'b11:   grant_next = ptr_reg ? 2'b10 : 2'b01;
                default: grant_next = 2'b00;
            endcase
        end
    end

    // A request stops counting as pending once it is granted and while its ack is out.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            assign pend_next[gi] = req_vec[gi] & ~grant_next[gi] &
                                   ~(state_reg == COOLDOWN && last_grant_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            vblnk_reg       <= 1'b0;
            ptr_reg         <= 1'b0;
            last_grant_reg  <= 1'b0;
            ack_reg         <= 2'b00;
            pending_reg     <= 1'b0;
            fill_reg        <= DEFAULT_FILL;
            bord_reg        <= 1'b1;
            blank_reg       <= (STARTUP_FRAMES != 0);
            startup_cnt_reg <= '0;
            frame_cnt_reg   <= 16'd0;
        end else begin
            vblnk_reg   <= vblnk_in;
            ack_reg     <= grant_next;
            pending_reg <= |pend_next;

            if (vbl_rise) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end

            if (vbl_rise && blank_reg) begin
                if (startup_cnt_reg == SW'(STARTUP_FRAMES - 1)) begin
                    blank_reg <= 1'b0;
                end else begin
                    startup_cnt_reg <= startup_cnt_reg + SW'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        state_reg <= WAIT_VBL;
                    end
                end
                WAIT_VBL: begin
                    if (!(|req_vec)) begin
                        state_reg <= IDLE;
                    end else if (vbl_rise) begin
                        state_reg      <= COOLDOWN;
                        ptr_reg        <= grant_next[0];
                        last_grant_reg <= grant_next[1];
                        if (grant_next[1]) begin
                            fill_reg <= fill1;
                            bord_reg <= bord1;
                        end else begin
                            fill_reg <= fill0;
                            bord_reg <= bord0;
                        end
                    end
                end
                COOLDOWN: begin
                    // The requester just acked is ignored here; only the other one can re-arm.
                    if (last_grant_reg ? req0 : req1) begin
                        state_reg <= WAIT_VBL;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack0          = ack_reg[0];
    assign ack1          = ack_reg[1];
    assign fill_rgb_out  = fill_reg;
    assign border_en_out = bord_reg;
    assign blank_out     = blank_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign pending       = pending_reg;

endmodule
